// File: rtl/nios2_mul_pkg.sv
// rtl/nios2_mul_pkg.sv - shared types and helpers for the multiplier result combiner
package nios2_mul_pkg;

    localparam int MUL_TAG_W_DEF = 5;

    typedef struct packed {
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
    } mul_pp_t;

    // Only the low halves of the cross products reach the low product word.
    function automatic logic [15:0] cross_lo16(input logic [31:0] p2, input logic [31:0] p3);
        return p2[15:0] + p3[15:0];
    endfunction

endpackage

// File: rtl/nios2_mul_pipe_stage.sv
// rtl/nios2_mul_pipe_stage.sv - valid/ready register slice with flush
module nios2_mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         v_q, v_d;
    logic [W-1:0] data_q, data_d;
    logic         adv;

    always_comb begin
        adv    = !v_q || out_ready;
        v_d    = v_q;
        data_d = data_q;
        if (adv) begin
            v_d = in_valid;
            // Payload is captured only for a real, surviving transfer.
            if (in_valid && !flush) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q;
    assign out_data  = data_q;

endmodule

// File: rtl/nios2_mul_result_combiner.sv
// rtl/nios2_mul_result_combiner.sv - folds 16x16 partial products into the low product word
module nios2_mul_result_combiner
    import nios2_mul_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             M_mul_valid,
    input  logic [TAG_W-1:0] M_mul_dst,
    output logic             M_mul_ready,
    input  logic             A_flush,
    input  logic             A_ready,
    output logic             A_mul_valid,
    output logic [31:0]      A_mul_result,
    output logic [TAG_W-1:0] A_mul_dst,
    output logic [CNT_W-1:0] mul_done_cnt,
    input  logic             clr_cnt
);

    localparam int S1_W = 32 + 16 + TAG_W;
    localparam int S2_W = 32 + TAG_W;

    mul_pp_t          pp;
    logic [S1_W-1:0]  s1_in, s1_out;
    logic [S2_W-1:0]  s2_in, s2_out;
    logic             s1_valid, s2_ready;
    logic [31:0]      s1_p1;
    logic [15:0]      s1_cross;
    logic [TAG_W-1:0] s1_dst;
    logic             unused_hi;
    logic             xfer;
    logic [CNT_W-1:0] mul_done_cnt_q, mul_done_cnt_d;

    assign pp        = '{p1: M_mul_cell_p1, p2: M_mul_cell_p2, p3: M_mul_cell_p3};
    assign unused_hi = ^{pp.p2[31:16], pp.p3[31:16]};
    assign s1_in     = {pp.p1, cross_lo16(pp.p2, pp.p3), M_mul_dst};

    nios2_mul_pipe_stage #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (A_flush),
        .in_valid  (M_mul_valid),
        .in_data   (s1_in),
        .in_ready  (M_mul_ready),
        .out_valid (s1_valid),
        .out_data  (s1_out),
        .out_ready (s2_ready)
    );

    assign {s1_p1, s1_cross, s1_dst} = s1_out;
    assign s2_in = {s1_p1 + {s1_cross, 16'h0000}, s1_dst};

    nios2_mul_pipe_stage #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (A_flush),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .in_ready  (s2_ready),
        .out_valid (A_mul_valid),
        .out_data  (s2_out),
        .out_ready (A_ready)
    );

    assign {A_mul_result, A_mul_dst} = s2_out;

    // A transfer in a flush cycle still leaves the pipe, so it still counts.
    always_comb begin
        xfer           = A_mul_valid && A_ready;
        mul_done_cnt_d = mul_done_cnt_q;
        if (clr_cnt) begin
            mul_done_cnt_d = '0;
        end else if (xfer && (mul_done_cnt_q != {CNT_W{1'b1}})) begin
            mul_done_cnt_d = mul_done_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_done_cnt_q <= '0;
        end else begin
            mul_done_cnt_q <= mul_done_cnt_d;
        end
    end

    assign mul_done_cnt = mul_done_cnt_q;

endmodule

// File: doc/nios2_mul_result_combiner.md
Name: nios2_mul_result_combiner

Overview:
- Downstream neighbour of the CPU multiplier cell. Consumes its three registered 16x16 partial products: p1=lo*lo, p2=lo(src1)*hi(src2), p3=hi(src1)*lo(src2).
- Assembles the low 32 bits of the 32x32 product over a 2-stage valid/ready pipeline.
- Delivers the result, with its destination-register tag, to the A-stage writeback. Supports backpressure and flush, and keeps a completed-op counter.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside each product
- CNT_W, 16, width of completed-operation counter (saturating)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- M_mul_cell_p1  in  32  lo*lo partial product
- M_mul_cell_p2  in  32  lo(src1)*hi(src2) partial product
- M_mul_cell_p3  in  32  hi(src1)*lo(src2) partial product
- M_mul_valid  in  1  p1/p2/p3 and M_mul_dst valid this cycle
- M_mul_dst  in  TAG_W  destination tag
- M_mul_ready  out  1  combiner accepts input this cycle
- A_flush  in  1  synchronous pipeline flush
- A_ready  in  1  writeback consumer accepts output
- A_mul_valid  out  1  result valid
- A_mul_result  out  32  low 32 bits of product
- A_mul_dst  out  TAG_W  tag of result
- mul_done_cnt  out  CNT_W  number of results accepted by consumer
- clr_cnt  in  1  synchronous counter clear

Behaviour:
- Reset (async, reset_n=0): s1_v=0, s2_v=0, A_mul_valid=0, A_mul_result=0, A_mul_dst=0, mul_done_cnt=0. All data registers cleared.
- Stage 1 (on input accept): s1_p1<=p1; s1_cross<=p2[15:0]+p3[15:0], 16-bit with carry discarded; s1_dst<=M_mul_dst; s1_v<=1.
- Stage 2: A_mul_result<=s1_p1+{s1_cross,16'h0}, mod 2^32; A_mul_dst<=s1_dst; s2_v<=s1_v. A_mul_valid=s2_v.
- p2[31:16] and p3[31:16] are never used; hi*hi is not needed for the low word.
- Handshake:
  - s2_adv = !s2_v | A_ready
  - s1_adv = !s1_v | s2_adv
  - M_mul_ready = s1_adv (bubbles collapse)
  - Input accepted when M_mul_valid & M_mul_ready.
  - If s1_adv and no accept, s1_v<=0.
  - Output transfer when A_mul_valid & A_ready.
- Latency: accept at cycle N -> A_mul_valid at N+2 when A_ready held high. Throughput 1 op/cycle.
- Stall: while A_mul_valid & !A_ready, A_mul_result and A_mul_dst hold stable. Stage 1 holds if full. Data registers do not change when their stage is not advancing.
- Flush: A_flush=1 clears s1_v and s2_v next edge. Any input presented that cycle is dropped. A flush overrides a simultaneous accept. Counter is unaffected by the flush, except that a transfer occurring in the same cycle still counts.
- Counter: increments on each output transfer and saturates at 2^CNT_W-1.
  - clr_cnt sets it to 0 and wins over a simultaneous increment.
- Valid-with-X inputs: data registers only capture when their valid path advances. No X propagates to A_mul_result while A_mul_valid=0 after reset.

Decomposition:
- Shared package nios2_mul_pkg:
  - TAG_W default
  - typedef mul_pp_t (struct p1, p2, p3 of 32 bits)
  - function cross_lo16(p2,p3)
- One sub-module is natural: nios2_mul_pipe_stage, a generic valid/ready register slice with payload width parameter and flush. It is instantiated twice, with arithmetic between the instances.

Test Plan:
- Basic: src1=0x00010003, src2=0x00020005 (p1=0x0000000F, p2=0x00000006, p3=0x00000005), dst=7, A_ready=1 -> A_mul_valid two cycles later with A_mul_result=0x000B000F, A_mul_dst=7, mul_done_cnt=1.
- Wrap: p1=p2=p3=0xFFFE0001 (src -1*-1) -> A_mul_result=0x00000001, cross sum carry discarded.
- Back-to-back 4 ops with A_ready=1 -> 4 consecutive valid outputs, correct tag order, M_mul_ready never low.
- Backpressure:
  - A_ready=0 for 5 cycles with 3 ops offered -> 2 held in pipeline and M_mul_ready=0 from the 3rd offer.
  - Output stable throughout the stall.
  - Release -> all 3 drain in order with no loss or duplication.
- Flush with both stages full plus simultaneous input valid -> next cycle A_mul_valid=0, s1 empty, counter unchanged.
- Reset: reset_n asserted mid-stall -> immediate A_mul_valid=0, result 0, counter 0. After release, a new op yields a correct result at +2 cycles.
- Counter: CNT_W=2, 5 transfers -> counter saturates at 3. clr_cnt concurrent with a transfer -> 0.
